// File: rtl/sync_up_counter.sv
// rtl/sync_up_counter.sv - start/enable up-counter with one-shot or continuous wrap and terminal-count pulse
// Optional wrap counter output enabled by defining SYNC_UP_COUNTER_WRAP_COUNT_EN.
module sync_up_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic             one_shot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
`ifdef SYNC_UP_COUNTER_WRAP_COUNT_EN
    output logic             done,
    output logic [7:0]       wraps
`else
    output logic             done
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic             r_tc;
    logic             w_tc_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_one_shot;
    logic             w_one_shot_nxt;
`ifdef SYNC_UP_COUNTER_WRAP_COUNT_EN
    logic [7:0]       r_wraps;
    logic [7:0]       w_wraps_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_q        <= '0;
            r_tc       <= 1'b0;
            r_done     <= 1'b0;
            r_one_shot <= 1'b0;
`ifdef SYNC_UP_COUNTER_WRAP_COUNT_EN
            r_wraps    <= 8'd0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_q        <= w_q_nxt;
            r_tc       <= w_tc_nxt;
            r_done     <= w_done_nxt;
            r_one_shot <= w_one_shot_nxt;
`ifdef SYNC_UP_COUNTER_WRAP_COUNT_EN
            r_wraps    <= w_wraps_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_q_nxt        = r_q;
        w_tc_nxt       = 1'b0;
        w_done_nxt     = 1'b0;
        w_one_shot_nxt = r_one_shot;
`ifdef SYNC_UP_COUNTER_WRAP_COUNT_EN
        w_wraps_nxt    = r_wraps;
`endif
        if (load) begin
            // DONE is a one-cycle state and still retires to IDLE under load
            w_q_nxt = load_val;
            if (r_state == S_DONE) begin
                w_state_nxt = S_IDLE;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_q_nxt        = '0;
                        w_one_shot_nxt = one_shot;
                        w_state_nxt    = S_RUN;
`ifdef SYNC_UP_COUNTER_WRAP_COUNT_EN
                        w_wraps_nxt    = 8'd0;
`endif
                    end
                end
                S_RUN: begin
                    if (en) begin
                        if (r_q == max_val) begin
                            w_tc_nxt = 1'b1;
                            if (r_one_shot) begin
                                w_done_nxt  = 1'b1;
                                w_state_nxt = S_DONE;
                            end else begin
                                w_q_nxt = '0;
`ifdef SYNC_UP_COUNTER_WRAP_COUNT_EN
                                if (r_wraps != 8'hFF) begin
                                    w_wraps_nxt = r_wraps + 8'd1;
                                end
`endif
                            end
                        end else begin
                            w_q_nxt = r_q + WIDTH'(1);
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign q    = r_q;
    assign tc   = r_tc;
    assign done = r_done;
    assign busy = (r_state == S_RUN);
`ifdef SYNC_UP_COUNTER_WRAP_COUNT_EN
    assign wraps = r_wraps;
`endif

endmodule

// File: tb/tb_sync_up_counter.sv
// tb/tb_sync_up_counter.sv - randomized and directed self-checking bench for sync_up_counter
module tb_sync_up_counter;

    localparam int W   = 2;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         en = 1'b0;
    logic         one_shot = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] max_val = '0;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
    logic         done;
`ifdef SYNC_UP_COUNTER_WRAP_COUNT_EN
    logic [7:0]   wraps;
`endif

    sync_up_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .en       (en),
        .one_shot (one_shot),
        .load     (load),
        .load_val (load_val),
        .max_val  (max_val),
        .q        (q),
        .tc       (tc),
        .busy     (busy),
`ifdef SYNC_UP_COUNTER_WRAP_COUNT_EN
        .done     (done),
        .wraps    (wraps)
`else
        .done     (done)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference: phase 0 = idle, 1 = counting, 2 = finished pass
    int m_phase, m_q, m_single, m_tc, m_done, m_wraps;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_q = 0; m_single = 0; m_tc = 0; m_done = 0; m_wraps = 0;
    endtask

    task automatic model_edge();
        m_tc   = 0;
        m_done = 0;
        if (rst) begin
            model_reset();
        end else if (load) begin
            m_q = int'(load_val);
            if (m_phase == 2) m_phase = 0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_q = 0; m_single = int'(one_shot); m_phase = 1; m_wraps = 0;
            end
        end else if (m_phase == 1) begin
            if (en && m_q == int'(max_val)) begin
                m_tc = 1;
                if (m_single != 0) begin
                    m_done = 1; m_phase = 2;
                end else begin
                    m_q = 0;
                    if (m_wraps < 255) m_wraps = m_wraps + 1;
                end
            end else if (en) begin
                m_q = (m_q + 1) % MOD;
            end
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_q"},    32'(q),    32'(m_q));
        check({tag, "_tc"},   32'(tc),   32'(m_tc));
        check({tag, "_done"}, 32'(done), 32'(m_done));
        check({tag, "_busy"}, 32'(busy), 32'(m_phase == 1));
`ifdef SYNC_UP_COUNTER_WRAP_COUNT_EN
        check({tag, "_wraps"}, 32'(wraps), 32'(m_wraps));
`endif
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic drive(input logic s, input logic e, input logic os, input logic ld,
                         input int lv, input int mv);
        start = s; en = e; one_shot = os; load = ld;
        load_val = W'(lv); max_val = W'(mv);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        cyc("rst_hold");
        rst = 1'b0;
    endtask

    int seq32 [5] = '{1, 2, 3, 0, 1};
    int seq33 [4] = '{1, 2, 2, 2};
    int busy33[4] = '{1, 1, 0, 0};

    initial begin
        model_reset();
        @(negedge clk);
        check_all("reset");
        cyc("reset_hold");
        rst = 1'b0;

        // continuous wrap at max_val=3
        drive(1, 1, 0, 0, 0, 3);
        cyc("c_start");
        check("c_start_q0", 32'(q), 32'd0);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc("cont");
            check("cont_q", 32'(q), 32'(seq32[i]));
            check("cont_tc", 32'(tc), 32'(i == 3));
            check("cont_busy", 32'(busy), 32'd1);
        end

        // single pass to max_val=2
        do_reset();
        drive(1, 1, 1, 0, 0, 2);
        cyc("os_start");
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc("os");
            check("os_q", 32'(q), 32'(seq33[i]));
            check("os_done", 32'(done), 32'(i == 2));
            check("os_tc", 32'(tc), 32'(i == 2));
            check("os_busy", 32'(busy), 32'(busy33[i]));
        end

        // load beats count
        do_reset();
        drive(1, 1, 0, 0, 0, 3);
        cyc("ld_start");
        start = 1'b0;
        cyc("ld_q1");
        drive(0, 1, 0, 1, 3, 3);
        cyc("ld_load");
        check("ld_q3", 32'(q), 32'd3);
        check("ld_tc0", 32'(tc), 32'd0);
        load = 1'b0;
        cyc("ld_wrap");
        check("ld_wrap_q", 32'(q), 32'd0);
        check("ld_wrap_tc", 32'(tc), 32'd1);

        // enable gap with start ignored while running
        do_reset();
        drive(1, 1, 0, 0, 0, 3);
        cyc("gap_start");
        start = 1'b0;
        cyc("gap_q1");
        drive(1, 0, 1, 0, 0, 3);
        for (int i = 0; i < 4; i++) begin
            cyc("gap");
            check("gap_q", 32'(q), 32'd1);
            check("gap_busy", 32'(busy), 32'd1);
            check("gap_pulse", 32'(tc | done), 32'd0);
        end

        // asynchronous abort mid-pass
        do_reset();
        drive(1, 1, 1, 0, 0, 3);
        cyc("ab_start");
        start = 1'b0;
        cyc("ab_q1");
        cyc("ab_q2");
        check("ab_q2c", 32'(q), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("ab_q", 32'(q), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_tc", 32'(tc), 32'd0);
        model_reset();
        cyc("ab_hold");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc("ab_after");

`ifdef SYNC_UP_COUNTER_WRAP_COUNT_EN
        do_reset();
        drive(1, 1, 0, 0, 0, 1);
        cyc("wr_start");
        start = 1'b0;
        for (int i = 0; i < 10; i++) cyc("wr");
        check("wr_five", 32'(wraps), 32'd5);
        do_reset();
        drive(1, 1, 0, 0, 0, 1);
        cyc("wr_restart");
        check("wr_zero", 32'(wraps), 32'd0);
`endif

        // randomized traffic against the reference
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 4) == 0, ($urandom % 10) < 7, 1'($urandom),
                  ($urandom % 12) == 0, int'($urandom % MOD), int'($urandom % MOD));
            if (($urandom % 60) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                check_all("rnd_rst");
                cyc("rnd_rst_hold");
                rst = 1'b0;
            end else begin
                cyc("rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
